// File: rtl/mac_cluster_ctrl.sv
// mac_cluster_ctrl: job sequencer for one MAC quad-cluster.
// Takes a job (config word plus beat count) and pulses cset to load the config.
// It then streams operand beats with en set only on real beats, and flushes the
// cluster pipeline with zero operands. Finally it returns the four accumulators
// as one result word.
// Optional feature: define MAC_CTRL_ABORT_EN to add an 'abort' input that
// returns the sequencer to IDLE from any state and drops any pending result.
module mac_cluster_ctrl #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int MAC_PIPE_DEPTH = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
`ifdef MAC_CTRL_ABORT_EN
    input  logic                                    abort,
`endif
    input  logic                                    job_valid,
    output logic                                    job_ready,
    input  logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] job_cfg,
    input  logic [CNT_WIDTH-1:0]                    job_len,
    input  logic                                    op_valid,
    output logic                                    op_ready,
    input  logic [8*MAC_MIN_WIDTH-1:0]              op_data,
    output logic                                    mac_cset,
    output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic                                    mac_en,
    output logic [8*MAC_MIN_WIDTH-1:0]              mac_ops,
    input  logic [4*MAC_ACC_WIDTH-1:0]              mac_out,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [4*MAC_ACC_WIDTH-1:0]              res_data,
    output logic                                    busy
);

    localparam int CFG_W  = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH;
    localparam int OPS_W  = 8*MAC_MIN_WIDTH;
    localparam int OUT_W  = 4*MAC_ACC_WIDTH;
    // Drain counter must hold MAC_PIPE_DEPTH; +2 keeps the width >= 1 for depth 0.
    localparam int DCNT_W = $clog2(MAC_PIPE_DEPTH + 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CFG   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic [OPS_W-1:0]    ops_q, ops_d;
    logic                en_q, en_d;
    logic                cset_q, cset_d;
    logic                resv_q, resv_d;
    logic [OUT_W-1:0]    resd_q, resd_d;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            cfg_q   <= '0;
            ops_q   <= '0;
            en_q    <= 1'b0;
            cset_q  <= 1'b0;
            resv_q  <= 1'b0;
            resd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            cfg_q   <= cfg_d;
            ops_q   <= ops_d;
            en_q    <= en_d;
            cset_q  <= cset_d;
            resv_q  <= resv_d;
            resd_q  <= resd_d;
        end
    end

    // Next state and next values of every registered output.
    // DRAIN is entered holding MAC_PIPE_DEPTH in dcnt: when coming from RUN the
    // first DRAIN cycle still carries the final beat. Then MAC_PIPE_DEPTH
    // zero-operand en cycles follow, and the capture happens on the edge that
    // ends the last of them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        cfg_d   = cfg_q;
        ops_d   = ops_q;
        en_d    = 1'b0;
        cset_d  = 1'b0;
        resv_d  = resv_q;
        resd_d  = resd_q;
        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    cfg_d   = job_cfg;
                    cnt_d   = job_len;
                    cset_d  = 1'b1;
                    state_d = CFG;
                end
            end
            CFG: begin
                dcnt_d = DCNT_W'(MAC_PIPE_DEPTH);
                if (cnt_q != '0) begin
                    state_d = RUN;
                end else begin
                    // Configure-only: flush straight away with zero products.
                    en_d    = 1'b1;
                    ops_d   = '0;
                    state_d = DRAIN;
                end
            end
            RUN: begin
                if (op_valid) begin
                    ops_d = op_data;
                    en_d  = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_WIDTH'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dcnt_q == '0) begin
                    resd_d  = mac_out;
                    resv_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                    en_d   = 1'b1;
                    ops_d  = '0;
                end
            end
            DONE: begin
                if (res_ready) begin
                    resv_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef MAC_CTRL_ABORT_EN
        // Abort wins over every transition; the job config stays latched.
        if (abort) begin
            state_d = IDLE;
            cfg_d   = cfg_q;
            cnt_d   = cnt_q;
            en_d    = 1'b0;
            cset_d  = 1'b0;
            resv_d  = 1'b0;
        end
`endif
    end

    // Handshake readies and busy decode the state; job_ready is held low in reset.
    assign job_ready = rst && (state_q == IDLE);
    assign op_ready  = (state_q == RUN);
    assign busy      = (state_q != IDLE);

    assign mac_cset  = cset_q;
    assign mac_cfg   = cfg_q;
    assign mac_en    = en_q;
    assign mac_ops   = ops_q;
    assign res_valid = resv_q;
    assign res_data  = resd_q;

endmodule
